gpu_fbuffer_writer: RTL and testbench
=====================================

Name: gpu_fbuffer_writer

Overview:
Executes the microcode `gwfbuffer` operation for the GPU. It takes the two tile-row bit-plane bytes (BH/BL for background, SH/SL for sprites) and maps each 2-bit colour index through the selected palette. It packs the 8 resulting shades into one 16-bit framebuffer word and writes it at the current framebuffer address. Sprite rows use read-modify-write so that transparency and priority work. The microcode sequencer stalls on oBusy until oDone.

Parameters:
FB_ADDR_W, 13, framebuffer word-address width (8192 words = 32 tiles x 256 rows)
FB_DATA_W, 16, framebuffer word width (8 pixels x 2 bits); fixed at 16, other values unsupported

Ports:
iClock  input  1  system clock
iReset  input  1  synchronous, active-high reset
iStart  input  1  one-cycle request from sequencer (gwfbuffer decoded)
iIsSprite  input  1  0 = background row, 1 = sprite row
iHigh  input  8  BH/SH plane byte; supplies colour index bit 1
iLow  input  8  BL/SL plane byte; supplies colour index bit 0
iSpriteInfo  input  8  OAM attribute byte: [7] behind-BG, [5] X-flip, [4] palette (0=OBP0, 1=OBP1)
iBgp  input  8  background palette
iObp0  input  8  sprite palette 0
iObp1  input  8  sprite palette 1
iFbAddr  input  FB_ADDR_W  target word address (fbuffer_addr)
iFbRData  input  FB_DATA_W  framebuffer read data, valid one cycle after oFbRe
oFbAddr  output  FB_ADDR_W  framebuffer address
oFbRe  output  1  framebuffer read strobe
oFbWe  output  1  framebuffer write strobe
oFbWData  output  FB_DATA_W  framebuffer write data
oBusy  output  1  operation in progress
oDone  output  1  one-cycle completion pulse

Behaviour:
- Reset values: every output is 0; state is IDLE; pixel counter is 0; internal registers are 0.
- IDLE: on iStart=1, latch iHigh, iLow, iSpriteInfo, the selected palette (iBgp, or iObp0/iObp1 by info[4] when iIsSprite=1), iBgp, iFbAddr and iIsSprite.
  - Background request goes to SHADE.
  - Sprite request goes to RD.
- RD (sprite only), 1 cycle: oFbRe=1, oFbAddr=latched address.
- RDWAIT, 1 cycle: capture iFbRData into the merge register, then go to SHADE.
  - For background, the merge register is cleared to 0 at start.
- SHADE, 8 cycles, one pixel per cycle, counter n = 0..7:
  - Source bit is b = 7-n. With X-flip (sprite only), b = n.
  - Colour index idx = {high[b], low[b]}.
  - Shade = palette[2*idx+1 : 2*idx].
  - Pixel n occupies word bits [15-2n : 14-2n]; pixel 0 is the leftmost, in bits [15:14].
  - Background: always write the shade.
  - Sprite: leave the pixel unchanged if idx == 0 (transparent).
  - Sprite with info[7]=1: write only where the existing pixel equals BGP shade 0 (iBgp[1:0] latched); otherwise leave it unchanged.
- WR, 1 cycle: oFbWe=1, oFbAddr=latched address, oFbWData=merge register.
- DONE, 1 cycle: oDone=1, then return to IDLE.
- oBusy=1 in every state except IDLE.
- Latency from the iStart edge to the oDone cycle:
  - Background: 10 cycles (SHADE x8, WR, DONE).
  - Sprite: 12 cycles.
- Back-to-back: a new iStart is accepted in the cycle after DONE (state is IDLE).
- iStart while busy is ignored. There is no queueing and latched operands are not disturbed.
- Input changes after the iStart cycle have no effect on the operation in flight.
- oFbRe and oFbWe are never asserted together.
- oFbAddr is 0 when neither strobe is active.
- Reset in any state: return to IDLE next cycle, with no write strobe and no oDone. A partially built word is discarded.
- The address is used as latched. The block performs no increment or wrap; ginfbaddr is owned by the sequencer.

Test Plan:
- Background, identity palette: iBgp=0xE4, iHigh=0xFF, iLow=0x00 at addr 0x0010. Required: one write of 0xAAAA to 0x0010, oDone exactly 10 cycles after iStart, oBusy high for 10 cycles.
- Background, mixed pattern: iBgp=0xE4, iHigh=0xF0, iLow=0xCC → write 0xFA50. With iBgp=0x1B (inverted) the same bytes → write 0x05AF.
- Sprite transparency read-modify-write: framebuffer holds 0x5555, iHigh=0x80, iLow=0x00, info=0x00, iObp0=0xE4. Required: read then write 0x9555. With info=0x20 (X-flip) → 0x5556. oDone at 12 cycles.
- Sprite priority: info=0x80, iBgp=0xE4, iHigh=0xFF, iLow=0xFF, iObp0=0xE4. Existing word 0x0000 → write 0xFFFF. Existing word 0x5555 → write 0x5555 (unchanged).
- Sprite palette select: info=0x10, iObp1=0x00, iObp0=0xFF, iHigh=0xFF, iLow=0x00, existing word 0xFFFF → write 0x0000 (OBP1 used).
- Robustness, extra start: pulse iStart during SHADE → still exactly one write and one oDone.
- Robustness, reset: assert iReset during SHADE cycle 4 → no oFbWe, outputs 0 next cycle, and a fresh iStart completes normally.

Source files
------------

// File: rtl/gpu_fbuffer_writer.sv
// gpu_fbuffer_writer: executes the gwfbuffer microcode op.
// Shades one tile row through a palette and writes one packed framebuffer word.
module gpu_fbuffer_writer #(
    parameter int FB_ADDR_W = 13,
    parameter int FB_DATA_W = 16
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iIsSprite,
    input  logic [7:0]           iHigh,
    input  logic [7:0]           iLow,
    input  logic [7:0]           iSpriteInfo,
    input  logic [7:0]           iBgp,
    input  logic [7:0]           iObp0,
    input  logic [7:0]           iObp1,
    input  logic [FB_ADDR_W-1:0] iFbAddr,
    input  logic [FB_DATA_W-1:0] iFbRData,
    output logic [FB_ADDR_W-1:0] oFbAddr,
    output logic                 oFbRe,
    output logic                 oFbWe,
    output logic [FB_DATA_W-1:0] oFbWData,
    output logic                 oBusy,
    output logic                 oDone
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RDWAIT = 3'd2,
        S_SHADE  = 3'd3,
        S_WR     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_n;
    logic [7:0]             r_high;
    logic [7:0]             r_low;
    logic [7:0]             r_pal;
    logic [1:0]             r_bgp0;
    logic                   r_prio;
    logic                   r_flip;
    logic                   r_sprite;
    logic [FB_ADDR_W-1:0]   r_addr;
    logic [FB_DATA_W-1:0]   r_word;

    logic [2:0]             w_b;
    logic [1:0]             w_idx;
    logic [1:0]             w_shade;
    logic [3:0]             w_shift;
    logic [1:0]             w_old;
    logic                   w_pix_we;
    logic [FB_DATA_W-1:0]   w_word_next;
    logic                   w_unused_info;

    // Attribute bits that this op does not consume.
    assign w_unused_info = ^{iSpriteInfo[6], iSpriteInfo[3:0]};

    // Source bit, colour index and target bit position of the current pixel.
    always_comb begin
        w_b     = (r_sprite && r_flip) ? r_n : (3'd7 - r_n);
        w_idx   = {r_high[w_b], r_low[w_b]};
        w_shift = {3'd7 - r_n, 1'b0};
        w_old   = r_word[w_shift +: 2];
    end

    // Palette lookup for the current colour index.
    always_comb begin
        w_shade = r_pal[1:0];
        case (w_idx)
            2'd0: w_shade = r_pal[1:0];
            2'd1: w_shade = r_pal[3:2];
            2'd2: w_shade = r_pal[5:4];
            2'd3: w_shade = r_pal[7:6];
            default: w_shade = r_pal[1:0];
        endcase
    end

    // Merge rule: BG always writes; sprites skip idx 0 and honour priority.
    always_comb begin
        w_pix_we    = !r_sprite ||
                      ((w_idx != 2'd0) && (!r_prio || (w_old == r_bgp0)));
        w_word_next = r_word;
        if (w_pix_we)
            w_word_next[w_shift +: 2] = w_shade;
    end

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (iStart) w_next = iIsSprite ? S_RD : S_SHADE;
            S_RD:     w_next = S_RDWAIT;
            S_RDWAIT: w_next = S_SHADE;
            S_SHADE:  if (r_n == 3'd7) w_next = S_WR;
            S_WR:     w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Bus strobes and status decoded from the current state.
    always_comb begin
        oFbAddr  = '0;
        oFbRe    = 1'b0;
        oFbWe    = 1'b0;
        oFbWData = '0;
        oDone    = 1'b0;
        oBusy    = (r_state != S_IDLE);
        case (r_state)
            S_RD: begin
                oFbRe   = 1'b1;
                oFbAddr = r_addr;
            end
            S_WR: begin
                oFbWe    = 1'b1;
                oFbAddr  = r_addr;
                oFbWData = r_word;
            end
            S_DONE:  oDone = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, read-back capture and per-pixel merge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_n      <= '0;
            r_high   <= '0;
            r_low    <= '0;
            r_pal    <= '0;
            r_bgp0   <= '0;
            r_prio   <= 1'b0;
            r_flip   <= 1'b0;
            r_sprite <= 1'b0;
            r_addr   <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_n      <= '0;
                        r_high   <= iHigh;
                        r_low    <= iLow;
                        r_pal    <= !iIsSprite ? iBgp :
                                    (iSpriteInfo[4] ? iObp1 : iObp0);
                        r_bgp0   <= iBgp[1:0];
                        r_prio   <= iSpriteInfo[7];
                        r_flip   <= iSpriteInfo[5];
                        r_sprite <= iIsSprite;
                        r_addr   <= iFbAddr;
                        r_word   <= '0;
                    end
                end
                S_RDWAIT: r_word <= iFbRData;
                S_SHADE: begin
                    r_word <= w_word_next;
                    r_n    <= r_n + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fbuffer_writer.sv
// tb_gpu_fbuffer_writer: directed checks of the gwfbuffer writer.
// Framebuffer read port is a one-word model with one-cycle read latency.
module tb_gpu_fbuffer_writer;

    logic        clk;
    logic        iReset;
    logic        iStart;
    logic        iIsSprite;
    logic [7:0]  iHigh;
    logic [7:0]  iLow;
    logic [7:0]  iSpriteInfo;
    logic [7:0]  iBgp;
    logic [7:0]  iObp0;
    logic [7:0]  iObp1;
    logic [12:0] iFbAddr;
    logic [15:0] iFbRData;
    logic [12:0] oFbAddr;
    logic        oFbRe;
    logic        oFbWe;
    logic [15:0] oFbWData;
    logic        oBusy;
    logic        oDone;

    logic [15:0] mem_word;
    int          errors;
    int          checks;

    gpu_fbuffer_writer #(.FB_ADDR_W(13), .FB_DATA_W(16)) dut (
        .iClock      (clk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iIsSprite   (iIsSprite),
        .iHigh       (iHigh),
        .iLow        (iLow),
        .iSpriteInfo (iSpriteInfo),
        .iBgp        (iBgp),
        .iObp0       (iObp0),
        .iObp1       (iObp1),
        .iFbAddr     (iFbAddr),
        .iFbRData    (iFbRData),
        .oFbAddr     (oFbAddr),
        .oFbRe       (oFbRe),
        .oFbWe       (oFbWe),
        .oFbWData    (oFbWData),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data appears one cycle after the strobe; junk otherwise.
    always @(posedge clk) begin
        iFbRData <= oFbRe ? mem_word : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic spr,
                          input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] info, input logic [7:0] bgp,
                          input logic [7:0] o0, input logic [7:0] o1,
                          input logic [12:0] addr, input logic [15:0] mem,
                          input logic [15:0] exp_w, input int exp_lat,
                          input int extra_at, input int rst_at);
        int k, nwe, nre, done_k, ndone, busy_n, viol;
        logic [15:0] wd;
        logic [12:0] wa, ra;
        bit stop;
        k = 0; nwe = 0; nre = 0; done_k = 0; ndone = 0;
        busy_n = 0; viol = 0; wd = '0; wa = '0; ra = '0; stop = 0;
        mem_word    = mem;
        iIsSprite   = spr;
        iHigh       = hi;
        iLow        = lo;
        iSpriteInfo = info;
        iBgp        = bgp;
        iObp0       = o0;
        iObp1       = o1;
        iFbAddr     = addr;
        iStart      = 1'b1;
        while (!stop) begin
            @(negedge clk);
            k++;
            if (oBusy) busy_n++;
            if (oFbWe) begin nwe++; wd = oFbWData; wa = oFbAddr; end
            if (oFbRe) begin nre++; ra = oFbAddr; end
            if (oFbRe && oFbWe) viol++;
            if (!oFbRe && !oFbWe && oFbAddr != 13'd0) viol++;
            if (oDone) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
            if (k == 1) begin
                iStart      = 1'b0;
                iIsSprite   = ~spr;
                iHigh       = ~hi;
                iLow        = ~lo;
                iSpriteInfo = ~info;
                iBgp        = ~bgp;
                iObp0       = ~o0;
                iObp1       = ~o1;
                iFbAddr     = ~addr;
            end
            if (extra_at != 0 && k == extra_at) iStart = 1'b1;
            if (extra_at != 0 && k == extra_at + 1) iStart = 1'b0;
            if (rst_at != 0 && k == rst_at) iReset = 1'b1;
            if (rst_at != 0 && k == rst_at + 1) begin
                iReset = 1'b0;
                chk({tag, "_rst_busy"}, 32'(oBusy), 32'd0);
                chk({tag, "_rst_outs"},
                    {oFbAddr, oFbWData, oFbRe, oFbWe, oDone}, 32'd0);
                stop = 1;
            end
            if (done_k != 0 && k >= done_k + 2) stop = 1;
            if (k >= 40) stop = 1;
        end
        if (rst_at != 0) begin
            chk({tag, "_nwe"}, 32'(nwe), 32'd0);
            chk({tag, "_ndone"}, 32'(ndone), 32'd0);
        end else begin
            chk({tag, "_latency"}, 32'(done_k), 32'(exp_lat));
            chk({tag, "_ndone"}, 32'(ndone), 32'd1);
            chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
            chk({tag, "_nwe"}, 32'(nwe), 32'd1);
            chk({tag, "_wdata"}, 32'(wd), 32'(exp_w));
            chk({tag, "_waddr"}, 32'(wa), 32'(addr));
            chk({tag, "_nre"}, 32'(nre), spr ? 32'd1 : 32'd0);
            if (spr) chk({tag, "_raddr"}, 32'(ra), 32'(addr));
        end
        chk({tag, "_bus_rules"}, 32'(viol), 32'd0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        mem_word    = '0;
        iReset      = 1'b1;
        iStart      = 1'b0;
        iIsSprite   = 1'b0;
        iHigh       = '0;
        iLow        = '0;
        iSpriteInfo = '0;
        iBgp        = '0;
        iObp0       = '0;
        iObp1       = '0;
        iFbAddr     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(oBusy), 32'd0);
        chk("reset_done", 32'(oDone), 32'd0);
        chk("reset_re", 32'(oFbRe), 32'd0);
        chk("reset_we", 32'(oFbWe), 32'd0);
        chk("reset_addr", 32'(oFbAddr), 32'd0);
        chk("reset_wdata", 32'(oFbWData), 32'd0);
        iReset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(oBusy), 32'd0);

        run_op("bg_ident", 1'b0, 8'hFF, 8'h00, 8'h00, 8'hE4, 8'h00,
               8'h00, 13'h0010, 16'h1234, 16'hAAAA, 10, 0, 0);
        run_op("bg_mixed", 1'b0, 8'hF0, 8'hCC, 8'h00, 8'hE4, 8'h00,
               8'h00, 13'h0123, 16'h1234, 16'hFA50, 10, 0, 0);
        run_op("bg_invpal", 1'b0, 8'hF0, 8'hCC, 8'h00, 8'h1B, 8'h00,
               8'h00, 13'h1FFF, 16'h1234, 16'h05AF, 10, 0, 0);
        run_op("sp_transp", 1'b1, 8'h80, 8'h00, 8'h00, 8'hE4, 8'hE4,
               8'h00, 13'h0040, 16'h5555, 16'h9555, 12, 0, 0);
        run_op("sp_xflip", 1'b1, 8'h80, 8'h00, 8'h20, 8'hE4, 8'hE4,
               8'h00, 13'h0041, 16'h5555, 16'h5556, 12, 0, 0);
        run_op("sp_prio_0", 1'b1, 8'hFF, 8'hFF, 8'h80, 8'hE4, 8'hE4,
               8'h00, 13'h0800, 16'h0000, 16'hFFFF, 12, 0, 0);
        run_op("sp_prio_5", 1'b1, 8'hFF, 8'hFF, 8'h80, 8'hE4, 8'hE4,
               8'h00, 13'h0801, 16'h5555, 16'h5555, 12, 0, 0);
        run_op("sp_obp1", 1'b1, 8'hFF, 8'h00, 8'h10, 8'hE4, 8'hFF,
               8'h00, 13'h0002, 16'hFFFF, 16'h0000, 12, 0, 0);
        run_op("bg_extra", 1'b0, 8'hFF, 8'h00, 8'h00, 8'hE4, 8'h00,
               8'h00, 13'h0077, 16'h1234, 16'hAAAA, 10, 3, 0);
        run_op("bg_reset", 1'b0, 8'hF0, 8'hCC, 8'h00, 8'hE4, 8'h00,
               8'h00, 13'h0055, 16'h1234, 16'hFA50, 10, 0, 4);
        run_op("bg_after", 1'b0, 8'hF0, 8'hCC, 8'h00, 8'hE4, 8'h00,
               8'h00, 13'h0056, 16'h1234, 16'hFA50, 10, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
